// File: rtl/alarm_pkg.sv
// Shared types and widths for the alarm sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        DONE   = 2'd3
    } alarm_st_t;

    localparam int SEC_W = 12;
    localparam int SNZ_W = 3;
    localparam int DAYS  = 7;

    // Seconds counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [SEC_W-1:0] sat_inc(input logic [SEC_W-1:0] v);
        return (v == {SEC_W{1'b1}}) ? v : v + SEC_W'(1);
    endfunction

endpackage

// File: rtl/alarm_seq_ctrl_rise_det.sv
// Rising-edge detector: one history flop plus an AND gate.
// Latency: rise_o is combinational from x_i against last cycle's sample.
// Backpressure: none; samples every clock.
module rise_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic x_i,
    output logic rise_o
);

    logic x_q;

    // History flop; reset value chosen per instance so a level already high can be masked.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= RST_VAL;
        end else begin
            x_q <= x_i;
        end
    end

    assign rise_o = x_i & ~x_q;

endmodule

// File: rtl/alarm_seq_ctrl.sv
// Alarm ring/snooze/stop sequencer with auto-timeout and weekday muting; drives buzz.
// Latency: one clk from a triggering input edge to the state change seen on outputs.
// Backpressure: none; buttons and match are sampled every clk, seconds via sec_tick.
module alarm_seq_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned      SNOOZE_SEC = 540,
    parameter int unsigned      RING_SEC   = 60,
    parameter int unsigned      MAX_SNOOZE = 3,
    parameter logic [DAYS-1:0]  DAY_MASK   = 7'b1100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sec_tick,
    input  logic             match,
    input  logic             alarm_on,
    input  logic [2:0]       day,
    input  logic             snooze_btn,
    input  logic             stop_btn,
    output logic             buzz,
    output logic             snoozing,
    output logic [SNZ_W-1:0] snooze_cnt,
    output logic [1:0]       state_o
);

    localparam logic [SEC_W-1:0] RING_LAST = SEC_W'(RING_SEC - 1);
    localparam logic [SEC_W-1:0] SNZ_LAST  = SEC_W'(SNOOZE_SEC - 1);
    localparam logic [SNZ_W-1:0] SNZ_MAX   = SNZ_W'(MAX_SNOOZE);

    alarm_st_t        state_q, state_d;
    logic [SEC_W-1:0] sec_ctr_q, sec_ctr_d;
    logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;

    logic match_rise;
    logic snooze_rise;
    logic stop_rise;
    logic muted;
    logic ring_exp;
    logic snz_exp;
    logic snz_ok;

    // match history resets high so a match already active at reset release cannot ring.
    rise_det #(.RST_VAL(1'b1)) u_match_rd (
        .clk    (clk),
        .rst    (rst),
        .x_i    (match),
        .rise_o (match_rise)
    );

    rise_det #(.RST_VAL(1'b0)) u_snooze_rd (
        .clk    (clk),
        .rst    (rst),
        .x_i    (snooze_btn),
        .rise_o (snooze_rise)
    );

    rise_det #(.RST_VAL(1'b0)) u_stop_rd (
        .clk    (clk),
        .rst    (rst),
        .x_i    (stop_btn),
        .rise_o (stop_rise)
    );

    // Weekday mute lookup; an out-of-range day code (7) is never muted.
    always_comb begin
        muted = 1'b0;
        if (day < 3'(DAYS)) begin
            muted = DAY_MASK[day];
        end
    end

    // State register plus seconds and snooze counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sec_ctr_q <= '0;
            snz_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sec_ctr_q <= sec_ctr_d;
            snz_cnt_q <= snz_cnt_d;
        end
    end

    // Next-state: alarm switch off beats stop, stop beats snooze, any button beats timer expiry.
    always_comb begin
        state_d   = state_q;
        sec_ctr_d = sec_ctr_q;
        snz_cnt_d = snz_cnt_q;
        ring_exp  = sec_tick && (sec_ctr_q == RING_LAST);
        snz_exp   = sec_tick && (sec_ctr_q == SNZ_LAST);
        snz_ok    = snooze_rise && (snz_cnt_q < SNZ_MAX);

        if (state_q == IDLE) begin
            if (alarm_on && match_rise && !muted) begin
                state_d   = RING;
                sec_ctr_d = '0;
                snz_cnt_d = '0;
            end
        end else if (!alarm_on) begin
            // Cancelling the event leaves snz_cnt as-is until the next ring starts.
            state_d = IDLE;
        end else if (stop_rise) begin
            state_d = DONE;
        end else begin
            case (state_q)
                RING: begin
                    if (snz_ok) begin
                        state_d   = SNOOZE;
                        sec_ctr_d = '0;
                        snz_cnt_d = snz_cnt_q + SNZ_W'(1);
                    end else if (sec_tick) begin
                        // A snooze press at the limit falls through to normal timing.
                        sec_ctr_d = sat_inc(sec_ctr_q);
                        if (ring_exp) begin
                            state_d = DONE;
                        end
                    end
                end
                SNOOZE: begin
                    // Re-ring ignores match and the weekday mute.
                    if (sec_tick) begin
                        sec_ctr_d = sat_inc(sec_ctr_q);
                        if (snz_exp) begin
                            state_d   = RING;
                            sec_ctr_d = '0;
                        end
                    end
                end
                DONE: begin
                    // Hold off until the match minute ends so the same minute cannot re-ring.
                    if (!match) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign buzz       = (state_q == RING);
    assign snoozing   = (state_q == SNOOZE);
    assign snooze_cnt = snz_cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_alarm_seq_ctrl.sv
// Directed bench for alarm_seq_ctrl with a deadline-based reference model.
// Latency: model updates on each posedge; outputs compared on each negedge.
// Backpressure: n/a.
module tb_alarm_seq_ctrl;

    localparam int SNZ_S = 5;
    localparam int RING_S = 4;
    localparam int MAXS = 2;

    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;
    localparam int M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sec_tick = 1'b1;
    logic       match = 1'b0;
    logic       alarm_on = 1'b1;
    logic [2:0] day = 3'd0;
    logic       snooze_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic       buzz;
    logic       snoozing;
    logic [2:0] snooze_cnt;
    logic [1:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    alarm_seq_ctrl #(
        .SNOOZE_SEC (SNZ_S),
        .RING_SEC   (RING_S),
        .MAX_SNOOZE (MAXS),
        .DAY_MASK   (7'b1100000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sec_tick   (sec_tick),
        .match      (match),
        .alarm_on   (alarm_on),
        .day        (day),
        .snooze_btn (snooze_btn),
        .stop_btn   (stop_btn),
        .buzz       (buzz),
        .snoozing   (snoozing),
        .snooze_cnt (snooze_cnt),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases with absolute deadlines in clock edges (sec_tick is always 1).
    int  now = 0;
    int  m_mode = M_IDLE;
    int  m_uses = 0;
    int  m_deadline = 0;
    bit  m_valid = 1'b0;
    bit  pm = 1'b1, ps = 1'b0, pt = 1'b0;

    always @(posedge clk) begin
        bit mr, sr, tr, mute;
        now++;
        if (rst) begin
            m_mode = M_IDLE;
            m_uses = 0;
            pm = 1'b1;
            ps = 1'b0;
            pt = 1'b0;
        end else begin
            mr   = match && !pm;
            sr   = snooze_btn && !ps;
            tr   = stop_btn && !pt;
            mute = (day == 3'd5) || (day == 3'd6);
            if (m_mode == M_IDLE) begin
                if (alarm_on && mr && !mute) begin
                    m_mode = M_RING;
                    m_uses = 0;
                    m_deadline = now + RING_S;
                end
            end else if (!alarm_on) begin
                m_mode = M_IDLE;
            end else if (tr) begin
                m_mode = M_DONE;
            end else if (m_mode == M_RING && sr && m_uses < MAXS) begin
                m_mode = M_SNZ;
                m_uses++;
                m_deadline = now + SNZ_S;
            end else if (m_mode == M_RING && now == m_deadline) begin
                m_mode = M_DONE;
            end else if (m_mode == M_SNZ && now == m_deadline) begin
                m_mode = M_RING;
                m_deadline = now + RING_S;
            end else if (m_mode == M_DONE && !match) begin
                m_mode = M_IDLE;
            end
            pm = match;
            ps = snooze_btn;
            pt = stop_btn;
        end
        m_valid = 1'b1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("mdl_state", 32'(state_o), 32'(m_mode));
            check("mdl_buzz", 32'(buzz), 32'(m_mode == M_RING));
            check("mdl_snoozing", 32'(snoozing), 32'(m_mode == M_SNZ));
            check("mdl_cnt", 32'(snooze_cnt), 32'(m_uses));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step(2);
        check("rst_state", 32'(state_o), 0);
        check("rst_buzz", 32'(buzz), 0);
        check("rst_cnt", 32'(snooze_cnt), 0);
        rst = 1'b0;
        step(1);

        // 1: ring, auto-timeout after RING_S clks, back to idle when match drops
        match = 1'b1;
        step(1);
        check("t1_buzz_on", 32'(buzz), 1);
        step(3);
        check("t1_buzz_hold", 32'(buzz), 1);
        step(1);
        check("t1_buzz_off", 32'(buzz), 0);
        check("t1_done", 32'(state_o), 3);
        match = 1'b0;
        step(1);
        check("t1_idle", 32'(state_o), 0);

        // 2: snooze then re-ring after SNZ_S clks
        match = 1'b1;
        step(1);
        snooze_btn = 1'b1;
        step(1);
        check("t2_buzz", 32'(buzz), 0);
        check("t2_snoozing", 32'(snoozing), 1);
        check("t2_cnt", 32'(snooze_cnt), 1);
        snooze_btn = 1'b0;
        step(4);
        check("t2_still_snz", 32'(snoozing), 1);
        step(1);
        check("t2_rering", 32'(buzz), 1);

        // 3: second snooze, third press ignored at the limit, then timeout
        snooze_btn = 1'b1;
        step(1);
        check("t3_cnt2", 32'(snooze_cnt), 2);
        snooze_btn = 1'b0;
        step(5);
        check("t3_rering", 32'(buzz), 1);
        snooze_btn = 1'b1;
        step(1);
        check("t3_limit_buzz", 32'(buzz), 1);
        check("t3_limit_cnt", 32'(snooze_cnt), 2);
        snooze_btn = 1'b0;
        step(2);
        check("t3_hold", 32'(buzz), 1);
        step(1);
        check("t3_done", 32'(state_o), 3);
        match = 1'b0;
        step(1);
        check("t3_idle", 32'(state_o), 0);

        // 4: weekday muting
        day = 3'd5;
        match = 1'b1;
        step(1);
        check("t4_day5", 32'(state_o), 0);
        match = 1'b0;
        day = 3'd6;
        step(1);
        match = 1'b1;
        step(1);
        check("t4_day6", 32'(buzz), 0);
        match = 1'b0;
        day = 3'd4;
        step(1);
        match = 1'b1;
        step(1);
        check("t4_day4", 32'(buzz), 1);

        // 5: stop and snooze together, stop wins; no re-ring within the same match
        stop_btn = 1'b1;
        snooze_btn = 1'b1;
        step(1);
        check("t5_stop", 32'(state_o), 3);
        check("t5_cnt", 32'(snooze_cnt), 0);
        stop_btn = 1'b0;
        snooze_btn = 1'b0;
        step(6);
        check("t5_no_rering", 32'(state_o), 3);
        match = 1'b0;
        step(1);
        check("t5_idle", 32'(state_o), 0);
        match = 1'b1;
        step(1);
        check("t5_rering", 32'(buzz), 1);

        // 6: alarm_on off during snooze; reset during ring; match high at reset release
        snooze_btn = 1'b1;
        step(1);
        snooze_btn = 1'b0;
        alarm_on = 1'b0;
        step(1);
        check("t6_cancel", 32'(state_o), 0);
        check("t6_snoozing", 32'(snoozing), 0);
        check("t6_cnt_held", 32'(snooze_cnt), 1);
        alarm_on = 1'b1;
        match = 1'b0;
        step(1);
        match = 1'b1;
        step(1);
        check("t6_ring", 32'(buzz), 1);
        check("t6_cnt_clr", 32'(snooze_cnt), 0);
        rst = 1'b1;
        step(1);
        check("t6_rst_buzz", 32'(buzz), 0);
        step(1);
        rst = 1'b0;
        step(2);
        check("t6_no_ring", 32'(state_o), 0);
        match = 1'b0;
        step(1);
        match = 1'b1;
        step(1);
        check("t6_ring2", 32'(buzz), 1);
        alarm_on = 1'b0;
        step(1);
        check("t6_off_ring", 32'(state_o), 0);
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
